// File: rtl/mig_arb_pkg.sv
// Shared constants, FSM encoding and sizing helper for the MIG UI port arbiter.
package mig_arb_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    ST_CALIB = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ISSUE = 2'd2
  } arb_state_e;

  // Bits needed to name one of n requesters (never less than one bit).
  function automatic int unsigned port_id_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mig_arb_tag_fifo.sv
// In-order FIFO of requester ids for reads outstanding at the MIG UI.
module mig_arb_tag_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_id,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok_c;
  logic             pop_ok_c;

  assign o_full  = (cnt_q == CNT_W'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign o_head  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the same cycle frees an entry.
  assign pop_ok_c  = i_pop && !o_empty;
  assign push_ok_c = i_push && (!o_full || pop_ok_c);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok_c) begin
      mem_d[wr_ptr_q] = i_push_id;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok_c, pop_ok_c})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mig_port_arbiter.sv
// Shares one MIG UI command port among NUM_PORTS requesters with in-order read return.
// Define MIG_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module mig_port_arbiter
  import mig_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned APP_ADDR_WIDTH = 28,
  parameter int unsigned APP_DATA_WIDTH = 128,
  parameter int unsigned APP_MASK_WIDTH = 16,
  parameter int unsigned TAG_DEPTH      = 8
) (
  input  logic                                clk,
  input  logic                                i_rst_n,
  input  logic [NUM_PORTS-1:0]                i_p_req,
  input  logic [NUM_PORTS-1:0]                i_p_we,
  input  logic [NUM_PORTS*APP_ADDR_WIDTH-1:0] i_p_addr,
  input  logic [NUM_PORTS*APP_DATA_WIDTH-1:0] i_p_data,
  input  logic [NUM_PORTS*APP_MASK_WIDTH-1:0] i_p_mask,
  output logic [NUM_PORTS-1:0]                o_p_gnt,
  output logic [APP_DATA_WIDTH-1:0]           o_p_rdata,
  output logic [NUM_PORTS-1:0]                o_p_rvalid,
  output logic                                o_rd_en,
  output logic                                o_wr_en,
  output logic [APP_ADDR_WIDTH-1:0]           o_addr,
  output logic [APP_DATA_WIDTH-1:0]           o_data,
  output logic [APP_MASK_WIDTH-1:0]           o_mask,
  input  logic                                i_ready,
  input  logic                                i_wdf_ready,
  input  logic [APP_DATA_WIDTH-1:0]           i_data,
  input  logic                                i_data_valid,
  input  logic                                i_init_calib_complete,
  output logic                                o_err
);

  localparam int unsigned AW = APP_ADDR_WIDTH;
  localparam int unsigned DW = APP_DATA_WIDTH;
  localparam int unsigned MW = APP_MASK_WIDTH;
  localparam int unsigned PW = port_id_w(NUM_PORTS);

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic                 rd_en_q, rd_en_d;
  logic                 wr_en_q, wr_en_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        data_q, data_d;
  logic [MW-1:0]        mask_q, mask_d;
  logic [PW-1:0]        win_q, win_d;
  logic                 err_q, err_d;
`ifndef MIG_ARB_FIXED_PRIO_EN
  logic [PW-1:0]        rr_q, rr_d;
`endif

  logic [AW-1:0]        p_addr [NUM_PORTS];
  logic [DW-1:0]        p_data [NUM_PORTS];
  logic [MW-1:0]        p_mask [NUM_PORTS];
  logic [NUM_PORTS-1:0] elig_c;
  logic                 found_c;
  logic [PW-1:0]        sel_c;
  logic                 accept_c;
  logic                 push_c;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [PW-1:0]        fifo_head;
  logic [2:0]           cmd_c;

  // Unpack the per-port buses; a read is only eligible while a tag slot is free.
  for (genvar k = 0; k < int'(NUM_PORTS); k++) begin : g_unpack
    assign p_addr[k] = i_p_addr[k*AW +: AW];
    assign p_data[k] = i_p_data[k*DW +: DW];
    assign p_mask[k] = i_p_mask[k*MW +: MW];
    assign elig_c[k] = i_p_req[k] && (i_p_we[k] || !fifo_full);
  end

  always_comb begin
    int unsigned idx;
    found_c = 1'b0;
    sel_c   = '0;
    idx     = 0;
`ifdef MIG_ARB_FIXED_PRIO_EN
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!found_c && elig_c[i]) begin
        found_c = 1'b1;
        sel_c   = PW'(i);
      end
    end
`else
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = (32'(rr_q) + i) % NUM_PORTS;
      if (!found_c && elig_c[idx]) begin
        found_c = 1'b1;
        sel_c   = PW'(idx);
      end
    end
`endif
  end

  assign accept_c = i_ready && (rd_en_q || i_wdf_ready);

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    rd_en_d = rd_en_q;
    wr_en_d = wr_en_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    win_d   = win_q;
    push_c  = 1'b0;
    cmd_c   = CMD_WRITE;
`ifndef MIG_ARB_FIXED_PRIO_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      ST_CALIB: begin
        if (i_init_calib_complete) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (found_c) begin
          cmd_c   = i_p_we[sel_c] ? CMD_WRITE : CMD_READ;
          rd_en_d = (cmd_c == CMD_READ);
          wr_en_d = (cmd_c == CMD_WRITE);
          addr_d  = p_addr[sel_c];
          data_d  = p_data[sel_c];
          mask_d  = p_mask[sel_c];
          gnt_d   = NUM_PORTS'(1) << sel_c;
          win_d   = sel_c;
`ifndef MIG_ARB_FIXED_PRIO_EN
          rr_d    = (32'(sel_c) == NUM_PORTS - 1) ? '0 : sel_c + PW'(1);
`endif
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (accept_c) begin
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          push_c  = rd_en_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_CALIB;
    endcase
  end

  // Read data with no outstanding tag is unroutable; flag it until reset.
  assign err_d = err_q || (i_data_valid && fifo_empty);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_CALIB;
      gnt_q   <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      win_q   <= '0;
      err_q   <= 1'b0;
`ifndef MIG_ARB_FIXED_PRIO_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      win_q   <= win_d;
      err_q   <= err_d;
`ifndef MIG_ARB_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

  mig_arb_tag_fifo #(
    .WIDTH (PW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .i_rst_n   (i_rst_n),
    .i_push    (push_c),
    .i_push_id (win_q),
    .i_pop     (i_data_valid),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty),
    .o_head    (fifo_head)
  );

  assign o_p_gnt    = gnt_q;
  assign o_rd_en    = rd_en_q;
  assign o_wr_en    = wr_en_q;
  assign o_addr     = addr_q;
  assign o_data     = data_q;
  assign o_mask     = mask_q;
  assign o_err      = err_q;
  assign o_p_rdata  = i_data;
  assign o_p_rvalid = (i_data_valid && !fifo_empty) ? (NUM_PORTS'(1) << fifo_head) : '0;

endmodule
